// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus bundle.
// The master side drives the two requesters and watches the register-file write port.
// The slave side is the arbiter.
interface regfile_wb_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   // Requester 0: ALU / execute writeback
   logic          req0_valid;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_data;
   logic          req0_ready;

   // Requester 1: load / CSR writeback
   logic          req1_valid;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_data;
   logic          req1_ready;

   // Register-file write port and status
   logic          rf_we;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_data;
   logic [31:0]   pend_mask;
   logic          starve_hit;

   modport master (
      output req0_valid, req0_addr, req0_data,
      input  req0_ready,
      output req1_valid, req1_addr, req1_data,
      input  req1_ready,
      input  rf_we, rf_addr, rf_data, pend_mask, starve_hit
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      output req0_ready,
      input  req1_valid, req1_addr, req1_data,
      output req1_ready,
      output rf_we, rf_addr, rf_data, pend_mask, starve_hit
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Two writeback sources share the single write port. One winner is picked per
// cycle, registered, and presented to the register file one cycle later.
// Writes to x0 complete their handshake but never assert the write enable.
// PRIO_MODE 0 alternates on ties; PRIO_MODE 1 favours req0 but hands the port
// to req1 once it has lost MAX_WAIT cycles in a row.
module regfile_wb_arbiter #(
   parameter int PRIO_MODE = 0,
   parameter int MAX_WAIT  = 4,
   parameter int DW        = 32,
   parameter int AW        = 5
) (
   input  logic                clk,
   input  logic                rst,
   regfile_wb_arbiter_if.slave bus
);
   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   // Remembers which requester took the most recent grant (for tie alternation).
   typedef enum logic {
      LAST_REQ0 = 1'b0,
      LAST_REQ1 = 1'b1
   } last_grant_e;

   last_grant_e   last_grant_q, last_grant_d;
   logic [3:0]    wait_cnt_q, wait_cnt_d;

   logic          grant0, grant1, any_grant, force1;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_data;

   logic          rf_we_d, rf_we_q;
   logic [AW-1:0] rf_addr_q;
   logic [DW-1:0] rf_data_q;
   logic [31:0]   pend_mask_d, pend_mask_q;

   // Pick at most one winner this cycle; a lone requester always wins.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      force1 = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         if (PRIO_MODE == 0) begin
            grant0 = (last_grant_q == LAST_REQ1);
            grant1 = (last_grant_q == LAST_REQ0);
         end else begin
            force1 = (wait_cnt_q == MAX_WAIT_C);
            grant0 = !force1;
            grant1 = force1;
         end
      end else begin
         grant0 = bus.req0_valid;
         grant1 = bus.req1_valid;
      end
   end

   // Next arbitration state: last winner and req1's consecutive-loss count.
   always_comb begin
      last_grant_d = last_grant_q;
      wait_cnt_d   = 4'd0;
      if (grant1) begin
         last_grant_d = LAST_REQ1;
      end else if (grant0) begin
         last_grant_d = LAST_REQ0;
      end
      if ((PRIO_MODE != 0) && bus.req1_valid && !grant1) begin
         wait_cnt_d = (wait_cnt_q < MAX_WAIT_C) ? (wait_cnt_q + 4'd1) : wait_cnt_q;
      end
   end

   assign any_grant = grant0 | grant1;
   assign win_addr  = grant1 ? bus.req1_addr : bus.req0_addr;
   assign win_data  = grant1 ? bus.req1_data : bus.req0_data;
   // x0 writes are swallowed here so the register file never sees them.
   assign rf_we_d   = any_grant && (win_addr != '0);

   // One-hot pending bit for the register about to be written.
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_pend
         assign pend_mask_d[gi] = rf_we_d && (32'(win_addr) == 32'(gi));
      end
   endgenerate

   // Arbitration state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_q <= LAST_REQ1;
         wait_cnt_q   <= 4'd0;
      end else begin
         last_grant_q <= last_grant_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   // Output stage: capture the winner; address/data hold when nobody is granted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_we_q     <= 1'b0;
         rf_addr_q   <= '0;
         rf_data_q   <= '0;
         pend_mask_q <= '0;
      end else begin
         rf_we_q     <= rf_we_d;
         pend_mask_q <= pend_mask_d;
         if (any_grant) begin
            rf_addr_q <= win_addr;
            rf_data_q <= win_data;
         end
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.starve_hit = force1;
   assign bus.rf_we      = rf_we_q;
   assign bus.rf_addr    = rf_addr_q;
   assign bus.rf_data    = rf_data_q;
   assign bus.pend_mask  = pend_mask_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: one round-robin instance and one fixed-priority
// instance (MAX_WAIT=4) share clock and reset. Directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_regfile_wb_arbiter;
   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int MAXW = 4;

   logic clk;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   regfile_wb_arbiter_if #(.DW(DW), .AW(AW)) bus_rr ();
   regfile_wb_arbiter_if #(.DW(DW), .AW(AW)) bus_fp ();

   regfile_wb_arbiter #(.PRIO_MODE(0), .MAX_WAIT(MAXW), .DW(DW), .AW(AW)) dut_rr (
      .clk (clk),
      .rst (rst),
      .bus (bus_rr)
   );

   regfile_wb_arbiter #(.PRIO_MODE(1), .MAX_WAIT(MAXW), .DW(DW), .AW(AW)) dut_fp (
      .clk (clk),
      .rst (rst),
      .bus (bus_fp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Requester state per instance [d] (0=rr, 1=fp) and requester [r]
   bit            pv [2][2];
   logic [AW-1:0] pa [2][2];
   logic [DW-1:0] pd [2][2];

   // Reference model: last winner per instance, req1 losing streak for fp
   int            m_last [2];
   int            m_lost;
   bit            e_we   [2];
   logic [AW-1:0] e_addr [2];
   logic [DW-1:0] e_data [2];
   logic [31:0]   e_mask [2];

   task automatic drive_all();
      bus_rr.req0_valid = pv[0][0]; bus_rr.req0_addr = pa[0][0]; bus_rr.req0_data = pd[0][0];
      bus_rr.req1_valid = pv[0][1]; bus_rr.req1_addr = pa[0][1]; bus_rr.req1_data = pd[0][1];
      bus_fp.req0_valid = pv[1][0]; bus_fp.req0_addr = pa[1][0]; bus_fp.req0_data = pd[1][0];
      bus_fp.req1_valid = pv[1][1]; bus_fp.req1_addr = pa[1][1]; bus_fp.req1_data = pd[1][1];
   endtask

   task automatic clear_inputs();
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 2; r++) begin
            pv[d][r] = 1'b0;
            pa[d][r] = '0;
            pd[d][r] = '0;
         end
      end
      drive_all();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      @(posedge clk);
      #1;
      rst = 1'b1;
      m_last[0] = 1;
      m_last[1] = 1;
      m_lost    = 0;
      for (int d = 0; d < 2; d++) begin
         e_we[d]   = 1'b0;
         e_addr[d] = '0;
         e_data[d] = '0;
         e_mask[d] = '0;
      end
   endtask

   // Winner under the arbitration rules: -1 none, 0 req0, 1 req1
   function automatic int pick(input int d, input bit v0, input bit v1);
      if (v0 && v1) begin
         if (d == 0) return (m_last[0] == 0) ? 1 : 0;
         return (m_lost >= MAXW) ? 1 : 0;
      end
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         pv[d][0] = 1'b1; pa[d][0] = 5'd9;  pd[d][0] = 32'h0000_0909;
         pv[d][1] = 1'b1; pa[d][1] = 5'd10; pd[d][1] = 32'h0000_0A0A;
      end
      drive_all();
      @(posedge clk);
      #1;
      n_tests++;
      if (bus_rr.rf_we !== 1'b0 || bus_fp.rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_we: got rr=%0b fp=%0b want 0", bus_rr.rf_we, bus_fp.rf_we);
      end
      n_tests++;
      if (bus_rr.pend_mask !== 32'h0 || bus_fp.pend_mask !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mask: got rr=%h fp=%h want 0", bus_rr.pend_mask, bus_fp.pend_mask);
      end
      n_tests++;
      if (bus_rr.rf_addr !== 5'd0 || bus_rr.rf_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_addr_data: got addr=%0d data=%h want 0/0", bus_rr.rf_addr, bus_rr.rf_data);
      end
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus_rr.req0_ready !== 1'b1 || bus_rr.req1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_first_tie: got r0=%0b r1=%0b want 1/0", bus_rr.req0_ready, bus_rr.req1_ready);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus_rr.rf_addr !== 5'd9 || bus_rr.rf_we !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_write: got addr=%0d we=%0b want 9/1", bus_rr.rf_addr, bus_rr.rf_we);
      end
      clear_inputs();
      $display("[TB] test_reset done");
   endtask

   task automatic test_single();
      do_reset();
      pv[0][0] = 1'b1; pa[0][0] = 5'd5; pd[0][0] = 32'hDEAD_BEEF;
      drive_all();
      @(negedge clk);
      n_tests++;
      if (bus_rr.req0_ready !== 1'b1 || bus_rr.req1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ready: got r0=%0b r1=%0b want 1/0", bus_rr.req0_ready, bus_rr.req1_ready);
      end
      @(posedge clk);
      #1;
      clear_inputs();
      n_tests++;
      if (bus_rr.rf_we !== 1'b1 || bus_rr.rf_addr !== 5'd5 || bus_rr.rf_data !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL single_write: got we=%0b addr=%0d data=%h want 1/5/deadbeef",
                  bus_rr.rf_we, bus_rr.rf_addr, bus_rr.rf_data);
      end
      n_tests++;
      if (bus_rr.pend_mask !== 32'h0000_0020) begin
         n_fail++;
         $display("FAIL single_mask: got %h want 00000020", bus_rr.pend_mask);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus_rr.rf_we !== 1'b0 || bus_rr.pend_mask !== 32'h0 || bus_rr.rf_addr !== 5'd5) begin
         n_fail++;
         $display("FAIL single_idle: got we=%0b mask=%h addr=%0d want 0/0/5",
                  bus_rr.rf_we, bus_rr.pend_mask, bus_rr.rf_addr);
      end
      $display("[TB] test_single done");
   endtask

   task automatic test_rr();
      logic [AW-1:0] want_addr;
      do_reset();
      pv[0][0] = 1'b1; pa[0][0] = 5'd1; pd[0][0] = 32'h1111_0000;
      pv[0][1] = 1'b1; pa[0][1] = 5'd2; pd[0][1] = 32'h2222_0000;
      drive_all();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_tests++;
         if (bus_rr.req0_ready !== (c % 2 == 0) || bus_rr.req1_ready !== (c % 2 == 1)) begin
            n_fail++;
            $display("FAIL rr_grant cyc%0d: got r0=%0b r1=%0b want r%0d", c,
                     bus_rr.req0_ready, bus_rr.req1_ready, c % 2);
         end
         @(posedge clk);
         #1;
         want_addr = (c % 2 == 0) ? 5'd1 : 5'd2;
         n_tests++;
         if (bus_rr.rf_addr !== want_addr || bus_rr.rf_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_addr cyc%0d: got addr=%0d we=%0b want %0d/1", c,
                     bus_rr.rf_addr, bus_rr.rf_we, want_addr);
         end
      end
      clear_inputs();
      $display("[TB] test_rr done");
   endtask

   task automatic test_starve();
      bit            w1;
      logic [AW-1:0] want_addr;
      do_reset();
      pv[1][0] = 1'b1; pa[1][0] = 5'd3; pd[1][0] = 32'h0000_0003;
      pv[1][1] = 1'b1; pa[1][1] = 5'd4; pd[1][1] = 32'h0000_0004;
      drive_all();
      for (int c = 0; c < 10; c++) begin
         w1 = (c % 5 == 4);
         @(negedge clk);
         n_tests++;
         if (bus_fp.req0_ready !== !w1 || bus_fp.req1_ready !== w1 || bus_fp.starve_hit !== w1) begin
            n_fail++;
            $display("FAIL starve cyc%0d: got r0=%0b r1=%0b hit=%0b want %0b/%0b/%0b", c,
                     bus_fp.req0_ready, bus_fp.req1_ready, bus_fp.starve_hit, !w1, w1, w1);
         end
         @(posedge clk);
         #1;
         want_addr = w1 ? 5'd4 : 5'd3;
         n_tests++;
         if (bus_fp.rf_addr !== want_addr || bus_fp.pend_mask !== (32'd1 << want_addr)) begin
            n_fail++;
            $display("FAIL starve_out cyc%0d: got addr=%0d mask=%h want %0d", c,
                     bus_fp.rf_addr, bus_fp.pend_mask, want_addr);
         end
      end
      clear_inputs();
      $display("[TB] test_starve done");
   endtask

   task automatic test_x0();
      do_reset();
      pv[0][1] = 1'b1; pa[0][1] = 5'd0; pd[0][1] = 32'h0000_1234;
      drive_all();
      @(negedge clk);
      n_tests++;
      if (bus_rr.req1_ready !== 1'b1 || bus_rr.req0_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL x0_ready: got r0=%0b r1=%0b want 0/1", bus_rr.req0_ready, bus_rr.req1_ready);
      end
      @(posedge clk);
      #1;
      clear_inputs();
      n_tests++;
      if (bus_rr.rf_we !== 1'b0 || bus_rr.pend_mask !== 32'h0) begin
         n_fail++;
         $display("FAIL x0_write: got we=%0b mask=%h want 0/0", bus_rr.rf_we, bus_rr.pend_mask);
      end
      n_tests++;
      if (bus_rr.rf_data !== 32'h0000_1234 || bus_rr.rf_addr !== 5'd0) begin
         n_fail++;
         $display("FAIL x0_data: got addr=%0d data=%h want 0/00001234", bus_rr.rf_addr, bus_rr.rf_data);
      end
      $display("[TB] test_x0 done");
   endtask

   task automatic test_async_reset();
      do_reset();
      pv[0][0] = 1'b1; pa[0][0] = 5'd7; pd[0][0] = 32'hCAFE_0007;
      drive_all();
      @(posedge clk);
      #1;
      clear_inputs();
      n_tests++;
      if (bus_rr.rf_we !== 1'b1 || bus_rr.pend_mask !== 32'h0000_0080) begin
         n_fail++;
         $display("FAIL async_pre: got we=%0b mask=%h want 1/00000080", bus_rr.rf_we, bus_rr.pend_mask);
      end
      #2;
      rst = 1'b0;
      #1;
      n_tests++;
      if (bus_rr.rf_we !== 1'b0 || bus_rr.pend_mask !== 32'h0 || bus_rr.rf_data !== 32'h0) begin
         n_fail++;
         $display("FAIL async_clear: got we=%0b mask=%h data=%h want 0/0/0",
                  bus_rr.rf_we, bus_rr.pend_mask, bus_rr.rf_data);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      $display("[TB] test_async_reset done");
   endtask

   task automatic test_random(input int n);
      bit   v0, v1, exp_st;
      int   w;
      bit   rdy   [2][2];
      bit   st    [2];
      bit   g_we  [2];
      logic [AW-1:0] g_addr [2];
      logic [DW-1:0] g_data [2];
      logic [31:0]   g_mask [2];
      do_reset();
      for (int i = 0; i < n; i++) begin
         for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
               if (!pv[d][r]) begin
                  pv[d][r] = ($urandom_range(0, 3) != 0);
                  pa[d][r] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                  pd[d][r] = $urandom;
               end
            end
         end
         drive_all();
         @(negedge clk);
         rdy[0][0] = bus_rr.req0_ready; rdy[0][1] = bus_rr.req1_ready; st[0] = bus_rr.starve_hit;
         rdy[1][0] = bus_fp.req0_ready; rdy[1][1] = bus_fp.req1_ready; st[1] = bus_fp.starve_hit;
         for (int d = 0; d < 2; d++) begin
            v0     = pv[d][0];
            v1     = pv[d][1];
            w      = pick(d, v0, v1);
            exp_st = (d == 1) && v0 && v1 && (m_lost >= MAXW);
            n_tests++;
            if (rdy[d][0] !== (w == 0) || rdy[d][1] !== (w == 1)) begin
               n_fail++;
               $display("FAIL rand_ready dut%0d cyc%0d: got r0=%0b r1=%0b want winner %0d",
                        d, i, rdy[d][0], rdy[d][1], w);
            end
            n_tests++;
            if (st[d] !== exp_st) begin
               n_fail++;
               $display("FAIL rand_starve dut%0d cyc%0d: got %0b want %0b", d, i, st[d], exp_st);
            end
            if (w >= 0) m_last[d] = w;
            if (d == 1) begin
               if (v1 && w != 1) m_lost = (m_lost < MAXW) ? m_lost + 1 : MAXW;
               else              m_lost = 0;
            end
            if (w >= 0) begin
               e_addr[d] = pa[d][w];
               e_data[d] = pd[d][w];
               e_we[d]   = (pa[d][w] != 5'd0);
               e_mask[d] = e_we[d] ? (32'd1 << pa[d][w]) : 32'd0;
               pv[d][w]  = 1'b0;
            end else begin
               e_we[d]   = 1'b0;
               e_mask[d] = 32'd0;
            end
         end
         @(posedge clk);
         #1;
         g_we[0] = bus_rr.rf_we; g_addr[0] = bus_rr.rf_addr; g_data[0] = bus_rr.rf_data; g_mask[0] = bus_rr.pend_mask;
         g_we[1] = bus_fp.rf_we; g_addr[1] = bus_fp.rf_addr; g_data[1] = bus_fp.rf_data; g_mask[1] = bus_fp.pend_mask;
         for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (g_we[d] !== e_we[d] || g_addr[d] !== e_addr[d] || g_data[d] !== e_data[d] ||
                g_mask[d] !== e_mask[d]) begin
               n_fail++;
               $display("FAIL rand_out dut%0d cyc%0d: got we=%0b a=%0d d=%h m=%h want we=%0b a=%0d d=%h m=%h",
                        d, i, g_we[d], g_addr[d], g_data[d], g_mask[d],
                        e_we[d], e_addr[d], e_data[d], e_mask[d]);
            end
         end
      end
      clear_inputs();
      $display("[TB] test_random done (%0d cycles)", n);
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      m_last[0] = 1;
      m_last[1] = 1;
      m_lost    = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_rr();
      test_starve();
      test_x0();
      test_async_reset();
      test_random(400);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach its end, %0d tests run", n_tests);
      $fatal(1, "timeout");
   end
endmodule
